wb_j1_mem_port: RTL and testbench
=================================

// Module: wb_j1_mem_port
// PURPOSE
//  Parametrised data-side memory port for a J1 core. Accepts one load/store per request from the core's
//  execute stage. Routes each request either to the shared Wishbone bus or to the per-core UART channel,
//  using an address region tag. The core stalls until done_o. Adds bus-error and timeout handling.
// PARAMETERS
//  DATA_W    32          data bus width (bits)
//  ADDR_W    32          address width (bits)
//  UART_W    8           UART data width; UART read data is zero-extended to DATA_W
//  UART_TAG  4'b1111     value of addr[ADDR_W-1 -: 4] that selects the UART channel
//  TIMEOUT   64          max BUS-state cycles without ack_i/err_i; 0 = timeout disabled
//  CPU_NUM   0           core index driven on cpu_num_o
//  NUM_W     3           width of cpu_num_o
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  req_i       in   1       core request; held with we_i/addr_i/wdata_i stable until done_o
//  we_i        in   1       1 = store, 0 = load
//  addr_i      in   ADDR_W  byte address from core (T)
//  wdata_i     in   DATA_W  store data from core (N)
//  rdata_o     out  DATA_W  load data; valid while done_o=1 and held until the next completion
//  done_o      out  1       one-cycle completion pulse
//  err_o       out  1       qualifies done_o: bus error or timeout
//  busy_o      out  1       state != IDLE
//  cpu_num_o   out  NUM_W   constant CPU_NUM
//  adr_o       out  ADDR_W  Wishbone address
//  dat_o       out  DATA_W  Wishbone write data
//  dat_i       in   DATA_W  Wishbone read data
//  we_o        out  1       Wishbone write enable
//  cyc_o       out  1       Wishbone cycle
//  stb_o       out  1       Wishbone strobe; equal to cyc_o
//  ack_i       in   1       Wishbone acknowledge
//  err_i       in   1       Wishbone error
//  uart_rd_o   out  1       UART read strobe, one cycle
//  uart_wr_o   out  1       UART write strobe, one cycle
//  uart_adr_o  out  1       UART register select = captured addr[0]
//  uart_dat_o  out  UART_W  UART write data = captured wdata[UART_W-1:0]
//  uart_dat_i  in   UART_W  UART read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (except cpu_num_o); timeout counter 0; rdata_o 0.
//    A reset mid-transaction drops cyc_o/stb_o at that edge and generates no done_o.
//  - Capture: in IDLE with req_i=1, latch we_i/addr_i/wdata_i into registers.
//    All bus and UART outputs drive from these registers only, never from the core inputs directly.
//  - States: IDLE -> BUS (tag != UART_TAG) or UART (tag == UART_TAG); BUS/UART -> DONE; DONE -> IDLE.
//    req_i is ignored outside IDLE.
//  - BUS:
//    - cyc_o=stb_o=1; adr_o/dat_o/we_o come from the captured request.
//    - ack_i: rdata_o <= dat_i on a load (unchanged on a store); err_o <= 0; go to DONE.
//    - err_i: rdata_o <= 0; err_o <= 1; go to DONE. err_i wins if ack_i and err_i arrive together.
//    - Timeout counter increments each BUS cycle. With TIMEOUT != 0 and the counter at TIMEOUT-1
//      and no ack_i/err_i: abort, err_o <= 1, rdata_o <= 0, go to DONE.
//      An ack_i on that same cycle wins over the timeout.
//    - The counter clears on BUS entry.
//  - UART: exactly one cycle. uart_rd_o = ~we; uart_wr_o = we.
//    On a load, rdata_o <= {zeros, uart_dat_i} in the same cycle. Go to DONE; err_o <= 0.
//  - DONE: done_o=1 for one cycle; cyc_o=0; return to IDLE.
//    Late ack_i/err_i arriving in DONE or IDLE are ignored.
//  - Latency (req_i high in IDLE at cycle 0):
//    - UART: done_o at cycle 2.
//    - Bus: ack at cycle k (k >= 1) gives done_o at k+1; minimum 2.
//  - Back-to-back: the earliest next accept is the cycle after DONE, so there is at most one
//    outstanding access at a time.
//  - Widths: counter width $clog2(TIMEOUT+1) (min 1). Address and data pass through unmodified;
//    there is no byte-select logic.
// TESTING
//  - Load 0x0000_0100, ack_i at cycle 3 with dat_i=0xDEAD_BEEF -> cyc_o high cycles 1-3;
//    done_o at cycle 4; rdata_o=0xDEAD_BEEF; err_o=0.
//  - Store 0x1234_5678 to 0x0000_0040, ack at cycle 1 -> we_o=1, dat_o=0x1234_5678 at cycle 1;
//    done_o at cycle 2; rdata_o unchanged.
//  - Load 0xF000_0001, uart_dat_i=0xA5 -> uart_rd_o=1 and uart_adr_o=1 at cycle 1 only;
//    done_o at cycle 2; rdata_o=0x0000_00A5.
//  - TIMEOUT=16, no ack -> cyc_o high exactly 16 cycles; done_o=1 with err_o=1 and rdata_o=0;
//    a late ack_i is ignored.
//  - ack_i and err_i together at cycle 2 -> err_o=1, rdata_o=0.
//    Repeat with ack_i only at cycle 16 under TIMEOUT=16 -> err_o=0.
//  - rst asserted at cycle 2 of a bus load -> cyc_o=0 from cycle 3, no done_o, busy_o=0;
//    the next req_i is serviced normally.

Source files
------------

// File: rtl/wb_j1_mem_port.sv
// wb_j1_mem_port
//   Data-side memory port for one J1 core. It takes a single load or store from
//   the execute stage. It sends the request either to the shared Wishbone bus or
//   to the core's private UART channel. The top four address bits select which one.
//   The core stalls until done_o pulses. err_o qualifies that pulse. It reports a
//   Wishbone error or a bus access that timed out.
//
//   Ports
//     clk, rst                 clock (rising edge), synchronous active-high reset
//     req_i/we_i/addr_i/wdata_i core request, held stable until done_o
//     rdata_o/done_o/err_o     completion: load data, one-cycle pulse, error flag
//     busy_o                   transaction in flight
//     cpu_num_o                constant core index
//     adr_o/dat_o/dat_i/we_o/cyc_o/stb_o/ack_i/err_i   Wishbone master side
//     uart_rd_o/uart_wr_o/uart_adr_o/uart_dat_o/uart_dat_i   UART channel

module wb_j1_mem_port #(
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 32,
    parameter int         UART_W   = 8,
    parameter logic [3:0] UART_TAG = 4'b1111,
    parameter int         TIMEOUT  = 64,
    parameter int         CPU_NUM  = 0,
    parameter int         NUM_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [NUM_W-1:0]  cpu_num_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic              ack_i,
    input  logic              err_i,
    output logic              uart_rd_o,
    output logic              uart_wr_o,
    output logic              uart_adr_o,
    output logic [UART_W-1:0] uart_dat_o,
    input  logic [UART_W-1:0] uart_dat_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_UART = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The counter must be able to hold TIMEOUT-1. Keep at least one bit so the
    // design still elaborates when the timeout is disabled.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout_hit;
    logic              is_uart;

    // The region tag is taken from the live address only while accepting a request.
    // After that, everything downstream uses the captured copy.
    assign is_uart     = (addr_i[ADDR_W-1 -: 4] == UART_TAG);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Main sequencer. It captures the request in IDLE, runs the bus or UART access,
    // records the result, and then spends exactly one cycle in DONE to pulse done_o.
    // On the bus, an error beats an ack. An ack beats a timeout that expires in the
    // same cycle. A late ack or error that arrives in DONE or IDLE has nowhere to go,
    // so it is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        cnt     <= '0;
                        state   <= is_uart ? ST_UART : ST_BUS;
                    end
                end
                ST_BUS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (err_i) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else if (ack_i) begin
                        if (!we_q) begin
                            rdata_q <= dat_i;
                        end
                        err_q <= 1'b0;
                        state <= ST_DONE;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_UART: begin
                    if (!we_q) begin
                        rdata_q <= DATA_W'(uart_dat_i);
                    end
                    err_q <= 1'b0;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All external strobes decode from the state register. All address and data
    // outputs come from the captured request, so the core inputs never reach the
    // bus combinationally.
    assign done_o     = (state == ST_DONE);
    assign busy_o     = (state != ST_IDLE);
    assign cyc_o      = (state == ST_BUS);
    assign stb_o      = (state == ST_BUS);
    assign we_o       = (state == ST_BUS) & we_q;
    assign adr_o      = addr_q;
    assign dat_o      = wdata_q;
    assign uart_rd_o  = (state == ST_UART) & ~we_q;
    assign uart_wr_o  = (state == ST_UART) & we_q;
    assign uart_adr_o = addr_q[0];
    assign uart_dat_o = wdata_q[UART_W-1:0];
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;
    assign cpu_num_o  = NUM_W'(CPU_NUM);

endmodule

// File: tb/tb_wb_j1_mem_port.sv
// tb_wb_j1_mem_port
//   Testbench for wb_j1_mem_port, built with TIMEOUT=16 and CPU_NUM=5.
//   Each transaction in the vector table pushes its expected completion onto a
//   queue. A monitor pops that entry whenever done_o pulses. Per-transaction
//   checks cover latency, Wishbone cycle length and the UART strobes.
//   A hand-written sequence resets the port in the middle of a transaction.

module tb_wb_j1_mem_port;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic [2:0]  cpu_num_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic        err_i;
    logic        uart_rd_o;
    logic        uart_wr_o;
    logic        uart_adr_o;
    logic [7:0]  uart_dat_o;
    logic [7:0]  uart_dat_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dat_in;
        logic [7:0]  uart_in;
        int          ack_cycle;
        logic        ack;
        logic        err;
        logic        late_ack;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_done;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[11];
    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    wb_j1_mem_port #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .UART_W  (8),
        .UART_TAG(4'b1111),
        .TIMEOUT (16),
        .CPU_NUM (5),
        .NUM_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .cpu_num_o (cpu_num_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i),
        .we_o      (we_o),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .ack_i     (ack_i),
        .err_i     (err_i),
        .uart_rd_o (uart_rd_o),
        .uart_wr_o (uart_wr_o),
        .uart_adr_o(uart_adr_o),
        .uart_dat_o(uart_dat_o),
        .uart_dat_i(uart_dat_i)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and keep the running counts.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor. Every done_o pulse must match the oldest outstanding
    // expectation. A pulse with nothing outstanding is an error.
    always @(negedge clk) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_done: got done_o=1, expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rdata_o", rdata_o, e.rdata);
                checkOutput("err_o", {31'b0, err_o}, {31'b0, e.err});
            end
        end
    end

    // Drive one request starting in cycle 0. Hold it until done_o. Check the address
    // and data path on every Wishbone cycle and on every UART strobe. The wait is
    // bounded: a missing done_o shows up as a latency failure.
    task automatic applyStimulus(input vec_t v);
        int   done_cyc;
        int   cyc_cnt;
        int   rd_cnt;
        int   wr_cnt;
        logic is_uart;
        exp_t e;
        is_uart  = (v.addr[31:28] == 4'hF);
        done_cyc = -1;
        cyc_cnt  = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        @(posedge clk);
        #1;
        req_i      = 1'b1;
        we_i       = v.we;
        addr_i     = v.addr;
        wdata_i    = v.wdata;
        dat_i      = v.dat_in;
        uart_dat_i = v.uart_in;
        ack_i      = 1'b0;
        err_i      = 1'b0;
        e.rdata    = v.exp_rdata;
        e.err      = v.exp_err;
        exp_q.push_back(e);
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            ack_i = (v.ack && c == v.ack_cycle) || (v.late_ack && c >= v.ack_cycle);
            err_i = v.err && c == v.ack_cycle;
            @(negedge clk);
            checkOutput("stb_eq_cyc", {31'b0, stb_o}, {31'b0, cyc_o});
            if (cyc_o) begin
                cyc_cnt++;
                checkOutput("adr_o", adr_o, v.addr);
                checkOutput("dat_o", dat_o, v.wdata);
                checkOutput("we_o", {31'b0, we_o}, {31'b0, v.we});
            end
            if (uart_rd_o || uart_wr_o) begin
                checkOutput("uart_adr_o", {31'b0, uart_adr_o}, {31'b0, v.addr[0]});
            end
            if (uart_rd_o) rd_cnt++;
            if (uart_wr_o) begin
                wr_cnt++;
                checkOutput("uart_dat_o", {24'b0, uart_dat_o}, {24'b0, v.wdata[7:0]});
            end
            if (done_o) begin
                done_cyc = c;
                req_i    = 1'b0;
            end
        end
        req_i = 1'b0;
        checkOutput("done_cycle", done_cyc, v.exp_done);
        checkOutput("cyc_cycles", cyc_cnt, v.exp_cyc);
        checkOutput("uart_rd_count", rd_cnt, (is_uart && !v.we) ? 1 : 0);
        checkOutput("uart_wr_count", wr_cnt, (is_uart && v.we) ? 1 : 0);
        if (done_cyc < 0) begin
            exp_q.delete();
        end
        if (v.late_ack) begin
            // Keep the stray ack high through an IDLE cycle as well.
            @(posedge clk);
            #1;
            ack_i = 1'b1;
            @(negedge clk);
            checkOutput("late_ack_rdata", rdata_o, v.exp_rdata);
            checkOutput("late_ack_busy", {31'b0, busy_o}, 32'd0);
        end
        ack_i = 1'b0;
        err_i = 1'b0;
    endtask

    // Bound the whole run so that a hung design still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected completion within 100 us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        // Fields: we, addr, wdata, dat_in, uart_in, ack_cycle, ack, err, late_ack,
        //         exp_rdata, exp_err, exp_done, exp_cyc
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 8'h00, 3, 1'b1, 1'b0, 1'b0,
                     32'hDEAD_BEEF, 1'b0, 4, 3};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0BAD_0BAD, 8'h00, 1, 1'b1, 1'b0, 1'b0,
                     32'hDEAD_BEEF, 1'b0, 2, 1};
        vecs[2]  = '{1'b0, 32'hF000_0001, 32'h0, 32'h0, 8'hA5, 1, 1'b0, 1'b0, 1'b0,
                     32'h0000_00A5, 1'b0, 2, 0};
        vecs[3]  = '{1'b1, 32'hF000_0000, 32'h0000_773C, 32'h0, 8'h11, 1, 1'b0, 1'b0, 1'b0,
                     32'h0000_00A5, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 32'h0000_0200, 32'h0, 32'h1111_1111, 8'h00, 2, 1'b1, 1'b1, 1'b0,
                     32'h0000_0000, 1'b1, 3, 2};
        vecs[5]  = '{1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 8'h00, 16, 1'b1, 1'b0, 1'b0,
                     32'hCAFE_F00D, 1'b0, 17, 16};
        vecs[6]  = '{1'b0, 32'h0000_0400, 32'h0, 32'h2222_2222, 8'h00, 17, 1'b0, 1'b0, 1'b1,
                     32'h0000_0000, 1'b1, 17, 16};
        vecs[7]  = '{1'b0, 32'h0000_0600, 32'h0, 32'h8765_4321, 8'h00, 5, 1'b1, 1'b0, 1'b0,
                     32'h8765_4321, 1'b0, 6, 5};
        vecs[8]  = '{1'b1, 32'h0000_0604, 32'hFFFF_0000, 32'h0, 8'h00, 2, 1'b0, 1'b1, 1'b0,
                     32'h0000_0000, 1'b1, 3, 2};
        vecs[9]  = '{1'b0, 32'hEFFF_FFFC, 32'h0, 32'h5A5A_5A5A, 8'h00, 1, 1'b1, 1'b0, 1'b0,
                     32'h5A5A_5A5A, 1'b0, 2, 1};
        vecs[10] = '{1'b0, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 8'h00, 2, 1'b1, 1'b0, 1'b0,
                     32'h1357_9BDF, 1'b0, 3, 2};

        rst        = 1'b1;
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
        dat_i      = '0;
        ack_i      = 1'b0;
        err_i      = 1'b0;
        uart_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_done", {31'b0, done_o}, 32'd0);
        checkOutput("reset_err", {31'b0, err_o}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("reset_cyc", {31'b0, cyc_o}, 32'd0);
        checkOutput("reset_uart_rd", {31'b0, uart_rd_o}, 32'd0);
        checkOutput("reset_adr", adr_o, 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        checkOutput("cpu_num", {29'b0, cpu_num_o}, 32'd5);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a bus load. The cycle must drop and no completion follows.
        @(posedge clk);
        #1;
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0000_0700;
        dat_i  = 32'h3333_3333;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_seq_cyc1", {31'b0, cyc_o}, 32'd1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_seq_cyc2", {31'b0, cyc_o}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_seq_cyc3", {31'b0, cyc_o}, 32'd0);
        checkOutput("rst_seq_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_seq_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_seq_rdata", rdata_o, 32'd0);

        applyStimulus(vecs[10]);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
